// File: rtl/itype_pkg.sv
// Shared opcodes, FSM state encodings, error codes and immediate-extension helpers
// for the I-type execution unit.
package itype_pkg;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MEM  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  // Helpers extend to the widest supported datapath; callers size-cast down.
  localparam int XW = 64;

  function automatic logic [XW-1:0] sext16(input logic [15:0] v);
    return {{(XW-16){v[15]}}, v};
  endfunction

  function automatic logic [XW-1:0] zext16(input logic [15:0] v);
    return {{(XW-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/itype_regfile.sv
// Register file: one write port, operand and debug combinational read ports.
// Reset loads reg[i]=i; register 0 is never written so it reads as zero.
module itype_regfile
  import itype_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we_i,
  input  logic [$clog2(REG_DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [$clog2(REG_DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]            rdata_o,
  input  logic [$clog2(REG_DEPTH)-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]            dbg_data_o
);

  logic [DATA_W-1:0] reg_q [REG_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        reg_q[i] <= DATA_W'(i);
      end
    end else if (we_i && (waddr_i != '0)) begin
      reg_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o    = reg_q[raddr_i];
  assign dbg_data_o = reg_q[dbg_addr_i];

endmodule

// File: rtl/itype_mem_unit.sv
// Multi-cycle I-type unit (ALU-immediate, lw/sw) with register file and inline data memory.
// IDLE -> EXEC -> [MEM x MEM_LAT] -> WB; done pulses in WB, in_ready only in IDLE.
module itype_mem_unit
  import itype_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_DEPTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter int MEM_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [5:0]                   opcode,
  input  logic [$clog2(REG_DEPTH)-1:0] rs,
  input  logic [$clog2(REG_DEPTH)-1:0] rt,
  input  logic [15:0]                  imm,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [DATA_W-1:0]            result,
  input  logic [$clog2(REG_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_data
);

  localparam int RA_W  = $clog2(REG_DEPTH);
  localparam int MA_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q;
  logic [RA_W-1:0]   rt_q;
  logic [15:0]       imm_q;
  logic [DATA_W-1:0] rs_val_q, rt_val_q, result_q;
  logic [MA_W-1:0]   idx_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [RA_W-1:0]   rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rf_we;

  logic [DATA_W-1:0] imm_sx, imm_zx, ea, alu_res;
  logic [1:0]        exec_code;
  logic              is_mem, mem_go;

  // The single operand port reads rs at accept and rt during EXEC; the file
  // cannot change in between because only this unit's WB writes it.
  assign rd_addr = (state_q == ST_IDLE) ? rs : rt_q;

  itype_regfile #(
    .DATA_W    (DATA_W),
    .REG_DEPTH (REG_DEPTH)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (rf_we),
    .waddr_i    (rt_q),
    .wdata_i    (result_q),
    .raddr_i    (rd_addr),
    .rdata_o    (rd_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign imm_sx = DATA_W'(sext16(imm_q));
  assign imm_zx = DATA_W'(zext16(imm_q));
  assign ea     = rs_val_q + imm_sx;
  assign is_mem = (op_q == OP_LW) || (op_q == OP_SW);
  assign mem_go = is_mem && (exec_code == ERR_NONE);

  always_comb begin
    alu_res   = '0;
    exec_code = ERR_NONE;
    case (op_q)
      OP_ADDI: alu_res = ea;
      OP_ANDI: alu_res = rs_val_q & imm_zx;
      OP_ORI:  alu_res = rs_val_q | imm_zx;
      OP_SLTI: alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs_val_q) < $signed(imm_sx))};
      OP_LW, OP_SW: begin
        if (ea[1:0] != 2'b00) begin
          exec_code = ERR_ALIGN;
        end else if (ea[DATA_W-1:2] >= (DATA_W-2)'(MEM_DEPTH)) begin
          exec_code = ERR_RANGE;
        end
      end
      default: exec_code = ERR_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (mem_go) begin
          state_d = ST_MEM;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (cnt_q == '0) state_d = ST_WB;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= opcode;
            rt_q     <= rt;
            imm_q    <= imm;
            rs_val_q <= rd_data;
          end
        end
        ST_EXEC: begin
          rt_val_q <= rd_data;
          idx_q    <= ea[MA_W+1:2];
          // Outputs only move on entry to WB so they hold between done pulses.
          if (!mem_go) begin
            result_q   <= (exec_code == ERR_NONE) ? alu_res : '0;
            err_q      <= (exec_code != ERR_NONE);
            err_code_q <= exec_code;
          end
        end
        ST_MEM: begin
          if (cnt_q == '0) begin
            if (op_q == OP_SW) mem_q[idx_q] <= rt_val_q;
            result_q   <= (op_q == OP_LW) ? mem_q[idx_q] : DATA_W'({idx_q, 2'b00});
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_we    = (state_q == ST_WB) && !err_q && (op_q != OP_SW) && (rt_q != '0);
  assign in_ready = (state_q == ST_IDLE);
  assign done     = (state_q == ST_WB);
  assign err      = err_q;
  assign err_code = err_code_q;
  assign result   = result_q;

endmodule

// File: tb/tb_itype_mem_unit.sv
// Directed vector bench for itype_mem_unit at default parameters.
module tb_itype_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, dbg_addr;
  logic [15:0] imm;
  logic        done, err;
  logic [1:0]  err_code;
  logic [31:0] result, dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itype_mem_unit dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .imm      (imm),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .result   (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        err;
    logic [1:0]  code;
    logic [31:0] res;
    int          lat;
    logic [4:0]  ca;
    logic [31:0] cv;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs_a, input logic [4:0] rt_a,
                              input logic [15:0] im, input logic e, input logic [1:0] c,
                              input logic [31:0] r, input int l, input logic [4:0] a,
                              input logic [31:0] v);
    vec_t t;
    t.op = op; t.rs = rs_a; t.rt = rt_a; t.imm = im; t.err = e; t.code = c;
    t.res = r; t.lat = l; t.ca = a; t.cv = v;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rs_a, input logic [4:0] rt_a,
                       input logic [15:0] im);
    in_valid = 1'b1;
    opcode   = op;
    rs       = rs_a;
    rt       = rt_a;
    imm      = im;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    chk($sformatf("v%0d_ready", k), in_ready, 1);
    issue(v.op, v.rs, v.rt, v.imm);
    wait_done(lat);
    chk($sformatf("v%0d_lat", k), lat, v.lat);
    chk($sformatf("v%0d_err", k), err, v.err);
    chk($sformatf("v%0d_code", k), err_code, v.code);
    chk($sformatf("v%0d_result", k), result, v.res);
    tick();
    dbg_addr = v.ca;
    #1;
    chk($sformatf("v%0d_reg%0d", k, v.ca), dbg_data, v.cv);
  endtask

  initial begin
    int lat;
    int done_seen;

    tv[0]  = mk(6'b001000, 5'd5,  5'd0,  16'h0001, 0, 2'b00, 32'h6,        2, 5'd0,  32'h0);
    tv[1]  = mk(6'b100011, 5'd4,  5'd5,  16'h0008, 0, 2'b00, 32'h3,        3, 5'd5,  32'h3);
    tv[2]  = mk(6'b101011, 5'd2,  5'd7,  16'h0006, 0, 2'b00, 32'h8,        3, 5'd7,  32'h7);
    tv[3]  = mk(6'b100011, 5'd0,  5'd9,  16'h0008, 0, 2'b00, 32'h7,        3, 5'd9,  32'h7);
    tv[4]  = mk(6'b001000, 5'd3,  5'd6,  16'hFFFF, 0, 2'b00, 32'h2,        2, 5'd6,  32'h2);
    tv[5]  = mk(6'b001010, 5'd6,  5'd8,  16'h0003, 0, 2'b00, 32'h1,        2, 5'd8,  32'h1);
    tv[6]  = mk(6'b100011, 5'd1,  5'd4,  16'h0000, 1, 2'b01, 32'h0,        2, 5'd4,  32'h4);
    tv[7]  = mk(6'b100011, 5'd0,  5'd10, 16'h0100, 1, 2'b10, 32'h0,        2, 5'd10, 32'hA);
    tv[8]  = mk(6'b000000, 5'd1,  5'd11, 16'h0000, 1, 2'b11, 32'h0,        2, 5'd11, 32'hB);
    tv[9]  = mk(6'b001100, 5'd7,  5'd12, 16'h0005, 0, 2'b00, 32'h5,        2, 5'd12, 32'h5);
    tv[10] = mk(6'b001101, 5'd12, 5'd13, 16'h00F0, 0, 2'b00, 32'hF5,       2, 5'd13, 32'hF5);
    tv[11] = mk(6'b001000, 5'd0,  5'd14, 16'h8000, 0, 2'b00, 32'hFFFF8000, 2, 5'd14, 32'hFFFF8000);
    tv[12] = mk(6'b001010, 5'd14, 5'd15, 16'h0000, 0, 2'b00, 32'h1,        2, 5'd15, 32'h1);
    tv[13] = mk(6'b001010, 5'd3,  5'd16, 16'hFFFF, 0, 2'b00, 32'h0,        2, 5'd16, 32'h0);
    tv[14] = mk(6'b101011, 5'd0,  5'd3,  16'hFFFC, 1, 2'b10, 32'h0,        2, 5'd3,  32'h3);
    tv[15] = mk(6'b100011, 5'd0,  5'd17, 16'h00FC, 0, 2'b00, 32'h3F,       3, 5'd17, 32'h3F);
    tv[16] = mk(6'b001000, 5'd0,  5'd19, 16'hFFFF, 0, 2'b00, 32'hFFFFFFFF, 2, 5'd19, 32'hFFFFFFFF);
    tv[17] = mk(6'b001000, 5'd19, 5'd20, 16'h0001, 0, 2'b00, 32'h0,        2, 5'd20, 32'h0);
    tv[18] = mk(6'b001100, 5'd14, 5'd21, 16'hFFFF, 0, 2'b00, 32'h8000,     2, 5'd21, 32'h8000);
    tv[19] = mk(6'b100011, 5'd0,  5'd22, 16'h0102, 1, 2'b01, 32'h0,        2, 5'd22, 32'h16);
    tv[20] = mk(6'b001000, 5'd0,  5'd23, 16'h0001, 0, 2'b00, 32'h1,        2, 5'd23, 32'h1);

    reset = 1'b1; in_valid = 1'b0; opcode = '0; rs = '0; rt = '0; imm = '0; dbg_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_result", result, 0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("rst_reg%0d", i), dbg_data, 32'(i));
    end

    for (int k = 0; k < NV; k++) run_vec(tv[k], k);

    // in_valid held through a busy instruction; changed fields must be ignored.
    in_valid = 1'b1; opcode = 6'b001000; rs = 5'd1; rt = 5'd24; imm = 16'd1;
    tick();
    rs = 5'd2; rt = 5'd25; imm = 16'd100;
    chk("hold_busy_ready", in_ready, 0);
    tick();
    chk("hold_done1", done, 1);
    chk("hold_result1", result, 32'd2);
    chk("hold_wb_ready", in_ready, 0);
    tick();
    chk("hold_idle_ready", in_ready, 1);
    chk("hold_done_low", done, 0);
    tick();
    in_valid = 1'b0;
    dbg_addr = 5'd24;
    #1;
    chk("hold_reg24", dbg_data, 32'd2);
    tick();
    chk("hold_done2", done, 1);
    chk("hold_result2", result, 32'd102);
    dbg_addr = 5'd25;
    #1;
    chk("hold_wb_old_reg25", dbg_data, 32'd25);
    tick();
    #1;
    chk("hold_new_reg25", dbg_data, 32'd102);

    // Reset while sw sits in MEM: no done, unit idle right after.
    issue(6'b101011, 5'd0, 5'd3, 16'd4);
    tick();
    chk("rmem_done_mem", done, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmem_ready", in_ready, 1);
    chk("rmem_done", done, 0);
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_seen++;
      tick();
    end
    chk("rmem_no_done", done_seen, 0);
    dbg_addr = 5'd24;
    #1;
    chk("rmem_reg24_reset", dbg_data, 32'd24);
    issue(6'b100011, 5'd0, 5'd26, 16'd4);
    wait_done(lat);
    chk("rmem_lw_lat", lat, 3);
    chk("rmem_mem1", result, 32'd1);
    chk("rmem_lw_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
